iob_cache_repl_ctrl: RTL and testbench



---
 rtl/iob_cache_repl_if.sv | 34 +++
 rtl/iob_cache_repl_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_iob_cache_repl_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_cache_repl_if.sv
// Request/response bundle between the cache tag path, the line-fill controller
// and the replacement controller.
interface iob_cache_repl_if #(
    parameter int N_WAYS   = 4,
    parameter int NLINES_W = 2,
    parameter int NWAYS_W  = $clog2(N_WAYS)
);
    logic                cke_i;
    logic                inv_i;
    logic                ready_o;
    logic                sel_en_i;
    logic [NLINES_W-1:0] sel_line_i;
    logic [N_WAYS-1:0]   valid_i;
    logic [N_WAYS-1:0]   lock_i;
    logic                upd_en_i;
    logic [NLINES_W-1:0] upd_line_i;
    logic [N_WAYS-1:0]   upd_hit_i;
    logic                victim_ack_o;
    logic [N_WAYS-1:0]   victim_o;
    logic [NWAYS_W-1:0]  victim_bin_o;
    logic                victim_none_o;

    modport master (
        output cke_i, inv_i, sel_en_i, sel_line_i, valid_i, lock_i,
               upd_en_i, upd_line_i, upd_hit_i,
        input  ready_o, victim_ack_o, victim_o, victim_bin_o, victim_none_o
    );

    modport slave (
        input  cke_i, inv_i, sel_en_i, sel_line_i, valid_i, lock_i,
               upd_en_i, upd_line_i, upd_hit_i,
        output ready_o, victim_ack_o, victim_o, victim_bin_o, victim_none_o
    );
endinterface

// File: rtl/iob_cache_repl_ctrl.sv
// Cache replacement controller: per-line policy state (LRU, PLRU_MRU, PLRU_TREE
// or LFSR random), init/invalidate sweep, valid- and lock-aware victim choice.
module iob_cache_repl_ctrl #(
    parameter int N_WAYS     = 4,
    parameter int NLINES_W   = 2,
    parameter int NWAYS_W    = $clog2(N_WAYS),
    parameter int REP_POLICY = 2
) (
    input logic             clk_i,
    input logic             arst_i,
    iob_cache_repl_if.slave bus
);
    // state | meaning
    // INIT  | sweeping each line's policy state to its reset value, requests ignored
    // IDLE  | ready; lookups and updates accepted
    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t              state;
    logic [NLINES_W-1:0] cnt;
    logic [15:0]         lfsr;
    logic                ready_r;
    logic                ack_r;
    logic                none_r;
    logic [N_WAYS-1:0]   victim_r;
    logic [NWAYS_W-1:0]  bin_r;

    logic [NWAYS_W-1:0]  pol_vic;
    logic [NWAYS_W-1:0]  vic_bin;
    logic [N_WAYS-1:0]   vic_oh;
    logic                vic_none;
    logic                vic_found;

    if (REP_POLICY != 3) begin : g_state
        localparam int ST_W = (REP_POLICY == 0) ? N_WAYS * NWAYS_W :
                              (REP_POLICY == 1) ? N_WAYS : N_WAYS - 1;

        logic [ST_W-1:0] mem [2**NLINES_W];
        logic [ST_W-1:0] st_rst;
        logic [ST_W-1:0] st_old;
        logic [ST_W-1:0] st_new;
        logic [ST_W-1:0] st_sel;
        logic            upd_acc;

        assign upd_acc = (state == S_IDLE) && bus.upd_en_i && (|bus.upd_hit_i);

        always_ff @(posedge clk_i) begin
            if (bus.cke_i) begin
                if (state == S_INIT) begin
                    mem[cnt] <= st_rst;
                end else if (upd_acc) begin
                    mem[bus.upd_line_i] <= st_new;
                end
            end
        end

        assign st_old = mem[bus.upd_line_i];
        // A lookup on the line being updated this cycle must see the new state.
        assign st_sel = (upd_acc && (bus.upd_line_i == bus.sel_line_i)) ?
                        st_new : mem[bus.sel_line_i];

        if (REP_POLICY == 0) begin : g_lru
            always_comb begin
                st_rst = '0;
                for (int i = 0; i < N_WAYS; i++) begin
                    st_rst[i*NWAYS_W +: NWAYS_W] = NWAYS_W'(i);
                end
            end

            always_comb begin
                logic [NWAYS_W-1:0] hit_rank;
                logic [NWAYS_W-1:0] r;
                hit_rank = '0;
                r        = '0;
                st_new   = st_old;
                for (int i = 0; i < N_WAYS; i++) begin
                    if (bus.upd_hit_i[i]) hit_rank = st_old[i*NWAYS_W +: NWAYS_W];
                end
                for (int i = 0; i < N_WAYS; i++) begin
                    r = st_old[i*NWAYS_W +: NWAYS_W];
                    if (bus.upd_hit_i[i]) begin
                        st_new[i*NWAYS_W +: NWAYS_W] = NWAYS_W'(N_WAYS - 1);
                    end else if (r > hit_rank) begin
                        st_new[i*NWAYS_W +: NWAYS_W] = r - NWAYS_W'(1);
                    end
                end
            end

            always_comb begin
                pol_vic = '0;
                for (int i = 0; i < N_WAYS; i++) begin
                    if (st_sel[i*NWAYS_W +: NWAYS_W] == '0) pol_vic = NWAYS_W'(i);
                end
            end
        end else if (REP_POLICY == 1) begin : g_mru
            logic [N_WAYS-1:0] mru_or;

            assign st_rst = '0;
            assign mru_or = st_old | bus.upd_hit_i;
            // Saturating would leave no candidate, so restart from the hit way.
            assign st_new = (&mru_or) ? bus.upd_hit_i : mru_or;

            always_comb begin
                pol_vic = '0;
                for (int i = N_WAYS - 1; i >= 0; i--) begin
                    if (!st_sel[i]) pol_vic = NWAYS_W'(i);
                end
            end
        end else begin : g_tree
            assign st_rst = '0;

            // Heap-ordered nodes: children of n are 2n+1 (left) and 2n+2 (right).
            always_comb begin
                int                 n;
                logic [NWAYS_W-1:0] h;
                h      = '0;
                n      = 0;
                st_new = st_old;
                for (int i = 0; i < N_WAYS; i++) begin
                    if (bus.upd_hit_i[i]) h = NWAYS_W'(i);
                end
                for (int l = 0; l < NWAYS_W; l++) begin
                    st_new[n] = ~h[NWAYS_W-1-l];
                    n = 2 * n + 1 + int'(h[NWAYS_W-1-l]);
                end
            end

            always_comb begin
                int n;
                n = 0;
                for (int l = 0; l < NWAYS_W; l++) begin
                    n = 2 * n + 1 + int'(st_sel[n]);
                end
                pol_vic = NWAYS_W'(n - (N_WAYS - 1));
            end
        end
    end else begin : g_rand
        assign pol_vic = lfsr[NWAYS_W-1:0];
    end

    always_comb begin
        vic_bin   = '0;
        vic_found = 1'b0;
        vic_none  = &bus.lock_i;
        for (int i = 0; i < N_WAYS; i++) begin
            if (!vic_found && !bus.valid_i[i] && !bus.lock_i[i]) begin
                vic_bin   = NWAYS_W'(i);
                vic_found = 1'b1;
            end
        end
        if (!vic_found && !bus.lock_i[pol_vic]) begin
            vic_bin   = pol_vic;
            vic_found = 1'b1;
        end
        for (int i = 0; i < N_WAYS; i++) begin
            if (!vic_found && !bus.lock_i[i]) begin
                vic_bin   = NWAYS_W'(i);
                vic_found = 1'b1;
            end
        end
    end

    assign vic_oh = vic_none ? '0 : (N_WAYS'(1) << vic_bin);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= S_INIT;
            cnt      <= '0;
            lfsr     <= 16'hACE1;
            ready_r  <= 1'b0;
            ack_r    <= 1'b0;
            none_r   <= 1'b0;
            victim_r <= '0;
            bin_r    <= '0;
        end else if (bus.cke_i) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            case (state)
                S_INIT: begin
                    ack_r <= 1'b0;
                    if (bus.inv_i) begin
                        cnt <= '0;
                    end else if (cnt == {NLINES_W{1'b1}}) begin
                        state   <= S_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        cnt <= cnt + NLINES_W'(1);
                    end
                end
                S_IDLE: begin
                    ack_r <= bus.sel_en_i;
                    if (bus.sel_en_i) begin
                        victim_r <= vic_oh;
                        bin_r    <= vic_bin;
                        none_r   <= vic_none;
                    end
                    if (bus.inv_i) begin
                        state   <= S_INIT;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_INIT;
                    cnt     <= '0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o       = ready_r;
    assign bus.victim_ack_o  = ack_r;
    assign bus.victim_o      = victim_r;
    assign bus.victim_bin_o  = bin_r;
    assign bus.victim_none_o = none_r;
endmodule

// File: tb/tb_iob_cache_repl_ctrl.sv
// Runs all four policies side by side on one stimulus stream and compares each
// against a behavioural model (recency queues, bitmasks, range-walk tree, LFSR).
module tb_iob_cache_repl_ctrl;
    logic       clk = 1'b0;
    logic       arst;
    logic       cke, inv, sel_en, upd_en;
    logic [1:0] sel_line, upd_line;
    logic [3:0] valid, lock, hit;

    logic [3:0] rdy_v, ack_v, none_v;
    logic [3:0] vic_v [4];
    logic [1:0] bin_v [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 4; p++) begin : g_dut
        iob_cache_repl_if #(.N_WAYS(4), .NLINES_W(2)) bus ();
        assign bus.cke_i      = cke;
        assign bus.inv_i      = inv;
        assign bus.sel_en_i   = sel_en;
        assign bus.sel_line_i = sel_line;
        assign bus.valid_i    = valid;
        assign bus.lock_i     = lock;
        assign bus.upd_en_i   = upd_en;
        assign bus.upd_line_i = upd_line;
        assign bus.upd_hit_i  = hit;
        iob_cache_repl_ctrl #(.N_WAYS(4), .NLINES_W(2), .REP_POLICY(p)) dut (
            .clk_i (clk),
            .arst_i(arst),
            .bus   (bus)
        );
        assign rdy_v[p]  = bus.ready_o;
        assign ack_v[p]  = bus.victim_ack_o;
        assign vic_v[p]  = bus.victim_o;
        assign bin_v[p]  = bus.victim_bin_o;
        assign none_v[p] = bus.victim_none_o;
    end

    // model state
    bit         m_idle;
    int         m_cnt;
    bit         m_ack;
    bit [15:0]  m_lfsr;
    logic [3:0] m_vic [4];
    int         m_bin [4];
    bit         m_none [4];
    int         lru_q [4][$];
    bit [3:0]   mru_st [4];
    bit [2:0]   tree_st [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void reset_line(int l);
        lru_q[l]   = {0, 1, 2, 3};
        mru_st[l]  = 4'b0000;
        tree_st[l] = 3'b000;
    endfunction

    function automatic void model_reset();
        m_idle = 0;
        m_cnt  = 0;
        m_ack  = 0;
        m_lfsr = 16'hACE1;
        for (int p = 0; p < 4; p++) begin
            m_vic[p] = 4'b0000; m_bin[p] = 0; m_none[p] = 0;
        end
        for (int l = 0; l < 4; l++) reset_line(l);
    endfunction

    function automatic void model_update(int l, logic [3:0] hv);
        int h = 0;
        int lo = 0, sz = 4, node = 0, half;
        bit [3:0] t;
        for (int i = 0; i < 4; i++) if (hv[i]) h = i;
        for (int k = 0; k < lru_q[l].size(); k++) begin
            if (lru_q[l][k] == h) begin
                lru_q[l].delete(k);
                break;
            end
        end
        lru_q[l].push_back(h);
        t = mru_st[l] | hv;
        mru_st[l] = (t == 4'hF) ? hv : t;
        while (sz > 1) begin
            half = sz / 2;
            if (h >= lo + half) begin
                tree_st[l][node] = 1'b0;
                lo   = lo + half;
                node = 2 * node + 2;
            end else begin
                tree_st[l][node] = 1'b1;
                node = 2 * node + 1;
            end
            sz = half;
        end
    endfunction

    function automatic int policy_victim(int p, int l);
        int lo = 0, sz = 4, node = 0, half;
        case (p)
            0: return lru_q[l][0];
            1: begin
                for (int i = 0; i < 4; i++) if (!mru_st[l][i]) return i;
                return 0;
            end
            2: begin
                while (sz > 1) begin
                    half = sz / 2;
                    if (tree_st[l][node]) begin
                        lo   = lo + half;
                        node = 2 * node + 2;
                    end else begin
                        node = 2 * node + 1;
                    end
                    sz = half;
                end
                return lo;
            end
            default: return int'(m_lfsr[1:0]);
        endcase
    endfunction

    function automatic void pick(input int pv, input logic [3:0] va, input logic [3:0] lk,
                                 output logic [3:0] vo, output int bo, output bit no);
        int c = -1;
        for (int i = 0; i < 4; i++) if (c < 0 && !va[i] && !lk[i]) c = i;
        if (c < 0 && !lk[pv]) c = pv;
        for (int i = 0; i < 4; i++) if (c < 0 && !lk[i]) c = i;
        if (c < 0) begin
            vo = 4'b0000; bo = 0; no = 1;
        end else begin
            vo = 4'(1 << c); bo = c; no = 0;
        end
    endfunction

    function automatic void model_step();
        bit fb;
        if (arst) begin
            model_reset();
            return;
        end
        if (!cke) return;
        if (m_idle) begin
            if (upd_en && hit != 4'b0000) model_update(int'(upd_line), hit);
            m_ack = sel_en;
            if (sel_en) begin
                for (int p = 0; p < 4; p++)
                    pick(policy_victim(p, int'(sel_line)), valid, lock, m_vic[p], m_bin[p], m_none[p]);
            end
            if (inv) begin
                m_idle = 0;
                m_cnt  = 0;
            end
        end else begin
            reset_line(m_cnt);
            m_ack = 0;
            if (inv) m_cnt = 0;
            else if (m_cnt == 3) m_idle = 1;
            else m_cnt++;
        end
        fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
        m_lfsr = (m_lfsr >> 1) | (16'(fb) << 15);
    endfunction

    task automatic compare_all();
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("p%0d_ready", p), 32'(rdy_v[p]), 32'(m_idle));
            chk($sformatf("p%0d_ack", p), 32'(ack_v[p]), 32'(m_ack));
            chk($sformatf("p%0d_victim", p), 32'(vic_v[p]), 32'(m_vic[p]));
            chk($sformatf("p%0d_victim_bin", p), 32'(bin_v[p]), 32'(m_bin[p]));
            chk($sformatf("p%0d_victim_none", p), 32'(none_v[p]), 32'(m_none[p]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        inv = 0; sel_en = 0; upd_en = 0;
        sel_line = 2'd0; upd_line = 2'd0;
        valid = 4'hF; lock = 4'h0; hit = 4'h0;
    endtask

    task automatic lookup(input logic [1:0] l, input logic [3:0] va, input logic [3:0] lk);
        sel_en = 1; sel_line = l; valid = va; lock = lk;
        cycle();
        sel_en = 0;
    endtask

    task automatic update(input logic [1:0] l, input logic [3:0] hv);
        upd_en = 1; upd_line = l; hit = hv;
        cycle();
        upd_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        arst = 1; cke = 1;
        idle_inputs();
        model_reset();
        cycle();
        cycle();
        arst = 0;

        // power-up sweep: four cycles not ready
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t1_ready_low", 32'(rdy_v[2]), 32'd0);
        end
        cycle();
        chk("t1_ready_high", 32'(rdy_v[2]), 32'd1);

        // tree: fresh line0, then train way0
        lookup(2'd0, 4'hF, 4'h0);
        chk("t2_ack", 32'(ack_v[2]), 32'd1);
        chk("t2_victim_fresh", 32'(vic_v[2]), 32'b0001);
        update(2'd0, 4'b0001);
        lookup(2'd0, 4'hF, 4'h0);
        chk("t2_victim_bin_trained", 32'(bin_v[2]), 32'd2);

        // lru on line1
        for (int w = 0; w < 4; w++) update(2'd1, 4'(1 << w));
        lookup(2'd1, 4'hF, 4'h0);
        chk("t3_lru_victim0", 32'(vic_v[0]), 32'b0001);
        update(2'd1, 4'b0001);
        lookup(2'd1, 4'hF, 4'h0);
        chk("t3_lru_victim1", 32'(bin_v[0]), 32'd1);
        lookup(2'd2, 4'hF, 4'h0);
        chk("t3_lru_other_line", 32'(bin_v[0]), 32'd0);

        // priority rules on untouched line3
        lookup(2'd3, 4'b1011, 4'h0);
        chk("t4_invalid_first", 32'(bin_v[2]), 32'd2);
        lookup(2'd3, 4'hF, 4'b0001);
        chk("t4_policy_locked", 32'(bin_v[2]), 32'd1);
        lookup(2'd3, 4'hF, 4'hF);
        chk("t4_none", 32'(none_v[2]), 32'd1);
        chk("t4_none_victim", 32'(vic_v[2]), 32'd0);

        // invalidate in IDLE
        inv = 1;
        cycle();
        inv = 0;
        chk("t6_ready_drop", 32'(rdy_v[2]), 32'd0);
        for (int k = 1; k < 4; k++) begin
            sel_en = (k == 1); sel_line = 2'd0; valid = 4'hF; lock = 4'h0;
            cycle();
            sel_en = 0;
            chk("t6_ready_low", 32'(rdy_v[2]), 32'd0);
            chk("t6_no_ack_in_init", 32'(ack_v[2]), 32'd0);
        end
        cycle();
        chk("t6_ready_back", 32'(rdy_v[2]), 32'd1);
        lookup(2'd0, 4'hF, 4'h0);
        chk("t6_tree_reset_victim", 32'(bin_v[2]), 32'd0);
        chk("t6_tree_reset_ack", 32'(ack_v[2]), 32'd1);

        // invalidate again mid-sweep: sweep restarts
        inv = 1;
        cycle();
        inv = 0;
        cycle();
        inv = 1;
        cycle();
        inv = 0;
        chk("t6_restart_low", 32'(rdy_v[2]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t6_restart_still_low", 32'(rdy_v[2]), 32'd0);
        end
        cycle();
        chk("t6_restart_high", 32'(rdy_v[2]), 32'd1);

        // mru bypass and wrap
        upd_en = 1; upd_line = 2'd0; hit = 4'b0001;
        lookup(2'd0, 4'hF, 4'h0);
        upd_en = 0;
        chk("t5_mru_bypass", 32'(vic_v[1]), 32'b0010);
        for (int w = 1; w < 4; w++) update(2'd0, 4'(1 << w));
        lookup(2'd0, 4'hF, 4'h0);
        chk("t5_mru_wrap", 32'(vic_v[1]), 32'b0001);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            cke      = ($urandom_range(0, 9) != 0);
            inv      = ($urandom_range(0, 39) == 0);
            sel_en   = 1'($urandom_range(0, 1));
            upd_en   = 1'($urandom_range(0, 1));
            sel_line = 2'($urandom_range(0, 3));
            upd_line = ($urandom_range(0, 2) == 0) ? sel_line : 2'($urandom_range(0, 3));
            valid    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            r        = int'($urandom_range(0, 9));
            lock     = (r < 6) ? 4'h0 : (r < 9) ? 4'($urandom) : 4'hF;
            hit      = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'(1 << $urandom_range(0, 3));
            cycle();
        end

        // asynchronous reset right after a lookup
        cke = 1;
        idle_inputs();
        for (int k = 0; k < 10 && !m_idle; k++) cycle();
        chk("t7_ready_before_lookup", 32'(rdy_v[2]), 32'd1);
        lookup(2'd1, 4'hF, 4'h0);
        chk("t7_ack_before_reset", 32'(ack_v[2]), 32'd1);
        #2;
        arst = 1;
        #1;
        model_reset();
        compare_all();
        chk("t7_ack_dropped", 32'(ack_v[2]), 32'd0);
        cycle();
        arst = 0;
        for (int k = 0; k < 6; k++) begin
            sel_en = 1'($urandom_range(0, 1));
            cycle();
        end
        sel_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
